// File: rtl/dmem_write_buffer.sv
// Store buffer between the core's data-memory write port and memory: a FIFO of
// pending stores drained over a req/ack handshake. Define WB_COALESCE_EN to merge
// a store into the newest entry when both target the same address.
module dmem_write_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     DM_writeEnable,
  input  logic [N-1:0]             DM_addr,
  input  logic [N-1:0]             DM_writeData,
  input  logic                     dump,
  output logic                     wb_full,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     mem_req,
  output logic [N-1:0]             mem_addr,
  output logic [N-1:0]             mem_wdata,
  input  logic                     mem_ack,
  output logic                     flush_done,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t         state, state_next;
  logic [N-1:0]   addr_mem [DEPTH];
  logic [N-1:0]   data_mem [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count, count_next;
  logic           flush_pending;
  logic           push, pop, drop, coalesce;

`ifdef WB_COALESCE_EN
  logic [PW-1:0]  newest;

  // The head entry is never merged into while it is on the bus, so mem_wdata
  // holds still until the ack.
  assign newest   = tail - PW'(1);
  assign coalesce = DM_writeEnable && (count != '0) && (addr_mem[newest] == DM_addr)
                    && !((state == REQ) && (newest == head));
`else
  assign coalesce = 1'b0;
`endif

  assign pop        = (state == REQ) && mem_ack;
  assign push       = DM_writeEnable && !wb_full && !coalesce;
  assign drop       = DM_writeEnable &&  wb_full && !coalesce;
  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      state         <= IDLE;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      flush_pending <= dump;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; entries are only read once count marks them valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      addr_mem[tail] <= DM_addr;
      data_mem[tail] <= DM_writeData;
    end
`ifdef WB_COALESCE_EN
    else if (coalesce) begin
      data_mem[newest] <= DM_writeData;
    end
`endif
  end

  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = REQ;
      REQ:     if (pop && (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign wb_count   = count;
  assign wb_full    = (count == CW'(DEPTH));
  assign mem_req    = (state == REQ);
  assign mem_addr   = mem_req ? addr_mem[head] : '0;
  assign mem_wdata  = mem_req ? data_mem[head] : '0;
  assign flush_done = flush_pending && (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: stores push expected memory writes,
// a negedge monitor compares every accepted req/ack against the queue head.
module tb_dmem_write_buffer;

  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLOCK_50 = 1'b0;
  logic          reset, DM_writeEnable, dump, mem_ack;
  logic [N-1:0]  DM_addr, DM_writeData, mem_addr, mem_wdata;
  logic          wb_full, mem_req, flush_done, overflow;
  logic [CW-1:0] wb_count;

  dmem_write_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .DM_writeEnable (DM_writeEnable),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .dump           (dump),
    .wb_full        (wb_full),
    .wb_count       (wb_count),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .flush_done     (flush_done),
    .overflow       (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [N-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  fire_cyc[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d, input bit accept);
    DM_writeEnable = 1'b1;
    DM_addr        = a;
    DM_writeData   = d;
    if (accept) exp_q.push_back('{addr: a, data: d});
    tick();
    DM_writeEnable = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: a handshake seen before the edge is the write memory accepts at it.
  always @(negedge CLOCK_50) begin
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected none", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        fire_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    reset = 1'b1; mem_ack = 1'b1; DM_writeEnable = 1'b0; dump = 1'b0;
    DM_addr = '0; DM_writeData = '0;

    // Reset held two edges with ack high
    tick(); tick();
    @(negedge CLOCK_50);
    check("rst_req",      mem_req,    0);
    check("rst_addr",     mem_addr,   0);
    check("rst_wdata",    mem_wdata,  0);
    check("rst_full",     wb_full,    0);
    check("rst_count",    wb_count,   0);
    check("rst_flush",    flush_done, 0);
    check("rst_overflow", overflow,   0);
    reset = 1'b0;
    tick();

    // Single store, ack tied high: request two edges after the store edge
    fire_cyc.delete();
    store(64'h10, 64'hDEAD, 1'b1);
    s = cyc;
    @(negedge CLOCK_50);
    check("single_no_bypass", mem_req, 0);
    tick();
    @(negedge CLOCK_50);
    check("single_req",   mem_req,   1);
    check("single_addr",  mem_addr,  64'h10);
    check("single_wdata", mem_wdata, 64'hDEAD);
    tick();
    @(negedge CLOCK_50);
    check("single_req_low", mem_req,  0);
    check("single_count",   wb_count, 0);
    check("single_latency", (fire_cyc.size() > 0) ? fire_cyc[0] : -1, s + 1);
    tick();

    // Fill with ack low, then overflow
    mem_ack = 1'b0;
    fire_cyc.delete();
    for (int i = 0; i < DEPTH; i++) store(64'(i * 8), 64'h100 + 64'(i), 1'b1);
    @(negedge CLOCK_50);
    check("fill_full",  wb_full,  1);
    check("fill_count", wb_count, 4);
    check("fill_head",  mem_addr, 64'h0);
    tick();
    store(64'h20, 64'h999, 1'b0);
    @(negedge CLOCK_50);
    check("ovf_flag",  overflow, 1);
    check("ovf_count", wb_count, 4);
    tick();
    // Pop while full does not open a slot for a store in the same cycle
    mem_ack = 1'b1;
    store(64'h28, 64'h777, 1'b0);
    @(negedge CLOCK_50);
    check("full_pop_no_push", wb_count, 3);
    tick();
    wait_drain(20);
    @(negedge CLOCK_50);
    check("fill_drained", wb_count, 0);
    check("ovf_sticky",   overflow, 1);
    for (int i = 1; i < 4; i++)
      check("fill_back_to_back", (fire_cyc.size() > i) ? fire_cyc[i] : -1,
            ((fire_cyc.size() > 0) ? fire_cyc[0] : -100) + i);
    tick();

    // Stall: request held stable for five cycles without ack
    mem_ack = 1'b0;
    store(64'h40, 64'hBEEF, 1'b1);
    store(64'h48, 64'hCAFE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("stall_addr",  mem_addr,  64'h40);
      check("stall_wdata", mem_wdata, 64'hBEEF);
      check("stall_count", wb_count,  2);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    @(negedge CLOCK_50);
    check("stall_pop_count", wb_count, 1);
    check("stall_next_addr", mem_addr, 64'h48);
    check("stall_next_req",  mem_req,  1);
    tick();
    mem_ack = 1'b1;
    wait_drain(10);
    mem_ack = 1'b0;
    tick();

    // Flush: three entries, ack every other cycle
    dump = 1'b1;
    store(64'h50, 64'h5, 1'b1);
    @(negedge CLOCK_50);
    check("flush_early", flush_done, 0);
    tick();
    store(64'h58, 64'h6, 1'b1);
    store(64'h60, 64'h7, 1'b1);
    for (int k = 0; k < 6; k++) begin
      mem_ack = (k % 2 == 0);
      tick();
      @(negedge CLOCK_50);
      check("flush_count", wb_count, 64'(2 - k / 2));
      check("flush_done",  flush_done, (k >= 4) ? 1 : 0);
    end
    tick();
    dump = 1'b0;
    mem_ack = 1'b0;
    tick();
    @(negedge CLOCK_50);
    check("flush_release", flush_done, 0);
    tick();

    // Repeated stores to one address
    store(64'h20, 64'h1, 1'b1);
`ifdef WB_COALESCE_EN
    store(64'h20, 64'h2, 1'b0);
    exp_q[exp_q.size() - 1].data = 64'h2;
`else
    store(64'h20, 64'h2, 1'b1);
`endif
    store(64'h20, 64'h3, 1'b1);
    @(negedge CLOCK_50);
`ifdef WB_COALESCE_EN
    check("same_addr_count", wb_count, 2);
`else
    check("same_addr_count", wb_count, 3);
`endif
    tick();
    mem_ack = 1'b1;
    wait_drain(10);
    mem_ack = 1'b0;
    tick();

    // Reset during an outstanding request; ack right after reset is ignored
    store(64'h70, 64'h77, 1'b1);
    tick();
    @(negedge CLOCK_50);
    check("midrst_req_before", mem_req, 1);
    tick();
    exp_q.delete();
    reset   = 1'b1;
    mem_ack = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("midrst_req",      mem_req,  0);
    check("midrst_count",    wb_count, 0);
    check("midrst_overflow", overflow, 0);
    tick();
    @(negedge CLOCK_50);
    check("midrst_idle", mem_req, 0);
    mem_ack = 1'b0;
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d writes outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
